// File: rtl/tone_pkg.sv
// tone_pkg: shared FSM states, step record and note divider table
package tone_pkg;

    typedef enum logic [2:0] {IDLE, MANUAL, LOAD, RETRIG, PLAY, DONE} state_e;

    typedef struct packed {
        logic       rest;
        logic [2:0] note;
        logic [7:0] dur;
    } step_t;

    localparam logic [31:0] NOTE_DIV [8] = '{
        32'd47801, 32'd42589, 32'd37936, 32'd35816,
        32'd31928, 32'd28409, 32'd25329, 32'd23900
    };

    function automatic logic [31:0] note_div(input logic [2:0] n);
        return NOTE_DIV[n];
    endfunction

endpackage

// File: rtl/tone_step_timer.sv
// tone_step_timer: duration-unit prescaler plus unit counter flagging the last cycle of a step
module tone_step_timer #(
    parameter int TICK_DIV = 500000
) (
    input  logic       inclk,
    input  logic       Reset,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] dur,
    output logic       expired
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    unit_q, unit_d;
    logic          wrap;

    // advance the prescaler while enabled; expired marks the final cycle of dur units
    always_comb begin
        wrap    = en && (presc_q == PW'(TICK_DIV - 1));
        presc_d = clear ? '0 : wrap ? '0 : en ? presc_q + PW'(1) : presc_q;
        unit_d  = clear ? '0 : wrap ? unit_q + 8'd1 : unit_q;
        expired = wrap && ((unit_q + 8'd1) == dur);
    end

    // counter registers with synchronous active-low reset
    always_ff @(posedge inclk) begin
        if (!Reset) begin
            presc_q <= '0;
            unit_q  <= '0;
        end else begin
            presc_q <= presc_d;
            unit_q  <= unit_d;
        end
    end

endmodule

// File: rtl/tone_scheduler.sv
// tone_scheduler: arbitrates manual notes and a stored note sequence into divider count/reset
module tone_scheduler
    import tone_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int SEQ_DEPTH = 16,
    parameter int COUNT_W   = 32
) (
    input  logic                         inclk,
    input  logic                         Reset,
    input  logic                         man_en,
    input  logic [2:0]                   man_note,
    input  logic                         seq_start,
    input  logic                         seq_stop,
    input  logic                         loop_en,
    input  logic                         wr_en,
    input  logic [$clog2(SEQ_DEPTH)-1:0] wr_addr,
    input  logic [3:0]                   wr_note,
    input  logic [7:0]                   wr_dur,
    output logic [COUNT_W-1:0]           div_count,
    output logic                         div_reset_n,
    output logic                         busy,
    output logic [$clog2(SEQ_DEPTH)-1:0] step_idx,
    output logic                         seq_done
);

    localparam int SW = $clog2(SEQ_DEPTH);

    state_e       state_q, state_d;
    logic [COUNT_W-1:0] div_count_q, div_count_d;
    logic         div_reset_n_q, div_reset_n_d;
    logic         busy_q, busy_d;
    logic [SW-1:0] step_idx_q, step_idx_d;
    logic         seq_done_q, seq_done_d;
    logic         cur_rest_q, cur_rest_d;
    logic [7:0]   cur_dur_q, cur_dur_d;
    logic [2:0]   last_note_q, last_note_d;
    step_t        tbl_q [SEQ_DEPTH];
    step_t        tbl_d [SEQ_DEPTH];
    step_t        rd;
    logic         expired;
    logic         last_step;

    assign rd        = tbl_q[step_idx_q];
    assign last_step = (step_idx_q == SW'(SEQ_DEPTH - 1));

    assign div_count   = div_count_q;
    assign div_reset_n = div_reset_n_q;
    assign busy        = busy_q;
    assign step_idx    = step_idx_q;
    assign seq_done    = seq_done_q;

    tone_step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .inclk   (inclk),
        .Reset   (Reset),
        .clear   (state_q == LOAD),
        .en      (state_q == PLAY),
        .dur     (cur_dur_q),
        .expired (expired)
    );

    // table write port; the playing step only sees new contents at its next LOAD
    always_comb begin
        tbl_d = tbl_q;
        if (wr_en) tbl_d[wr_addr] = {wr_note, wr_dur};
    end

    // table storage survives reset
    always_ff @(posedge inclk) begin
        tbl_q <= tbl_d;
    end

    // state and registered outputs
    always_ff @(posedge inclk) begin
        if (!Reset) begin
            state_q       <= IDLE;
            div_count_q   <= COUNT_W'(NOTE_DIV[0]);
            div_reset_n_q <= 1'b0;
            busy_q        <= 1'b0;
            step_idx_q    <= '0;
            seq_done_q    <= 1'b0;
            cur_rest_q    <= 1'b0;
            cur_dur_q     <= '0;
            last_note_q   <= '0;
        end else begin
            state_q       <= state_d;
            div_count_q   <= div_count_d;
            div_reset_n_q <= div_reset_n_d;
            busy_q        <= busy_d;
            step_idx_q    <= step_idx_d;
            seq_done_q    <= seq_done_d;
            cur_rest_q    <= cur_rest_d;
            cur_dur_q     <= cur_dur_d;
            last_note_q   <= last_note_d;
        end
    end

    // next state: sequencer preempts manual, stop beats start while busy
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = seq_start ? LOAD : man_en ? MANUAL : IDLE;
            MANUAL:  state_d = seq_start ? LOAD : man_en ? MANUAL : IDLE;
            LOAD:    state_d = (rd.dur == 8'd0) ? DONE : RETRIG;
            RETRIG:  state_d = PLAY;
            PLAY:    state_d = !expired ? PLAY : (last_step && !loop_en) ? DONE : LOAD;
            default: state_d = IDLE;
        endcase
        if (state_q inside {LOAD, RETRIG, PLAY}) state_d = seq_stop ? IDLE : seq_start ? LOAD : state_d;
    end

    // outputs computed from the upcoming state so every port comes straight from a flop
    always_comb begin
        div_count_d   = (state_d == MANUAL) ? COUNT_W'(note_div(man_note)) :
                        (state_q == LOAD && state_d == RETRIG && !rd.rest) ? COUNT_W'(note_div(rd.note)) :
                        div_count_q;
        div_reset_n_d = (state_d == MANUAL) ? (state_q != MANUAL || man_note == last_note_q) :
                        (state_d == PLAY) ? !cur_rest_q : 1'b0;
        busy_d        = state_d inside {LOAD, RETRIG, PLAY};
        seq_done_d    = (state_d == DONE);
        step_idx_d    = (state_d == IDLE || state_d == DONE || (seq_start && state_d == LOAD)) ? '0 :
                        (state_q == PLAY && state_d == LOAD) ? step_idx_q + SW'(1) : step_idx_q;
        cur_rest_d    = (state_q == LOAD) ? rd.rest : cur_rest_q;
        cur_dur_d     = (state_q == LOAD) ? rd.dur : cur_dur_q;
        last_note_d   = man_note;
    end

endmodule

// File: tb/tb_tone_scheduler.sv
// tb_tone_scheduler: directed and randomized checks against a step-schedule reference model
module tb_tone_scheduler;

    localparam int T = 4;

    logic       inclk = 1'b0;
    logic       Reset = 1'b0;
    logic       man_en = 1'b0;
    logic [2:0] man_note = '0;
    logic       seq_start = 1'b0;
    logic       seq_stop = 1'b0;
    logic       loop_en = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [3:0] wr_note = '0;
    logic [7:0] wr_dur = '0;
    logic [31:0] div_count;
    logic       div_reset_n;
    logic       busy;
    logic [3:0] step_idx;
    logic       seq_done;

    int errors = 0;
    int checks = 0;
    int nd [8] = '{47801, 42589, 37936, 35816, 31928, 28409, 25329, 23900};
    bit m_rest [16];
    int m_note [16];
    int m_dur [16];
    int m_div;
    int done_at;
    int busy_fall;
    int k;

    typedef struct {
        int div;
        bit rn;
        bit busy;
        int idx;
        bit done;
    } exp_t;

    exp_t exp_q [$];

    tone_scheduler #(.TICK_DIV(T), .SEQ_DEPTH(16), .COUNT_W(32)) dut (
        .inclk       (inclk),
        .Reset       (Reset),
        .man_en      (man_en),
        .man_note    (man_note),
        .seq_start   (seq_start),
        .seq_stop    (seq_stop),
        .loop_en     (loop_en),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_note     (wr_note),
        .wr_dur      (wr_dur),
        .div_count   (div_count),
        .div_reset_n (div_reset_n),
        .busy        (busy),
        .step_idx    (step_idx),
        .seq_done    (seq_done)
    );

    always #5 inclk = ~inclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_out(input string tag, input int dv, input bit rn, input bit bz, input bit dn);
        chk({tag, ".div_count"}, div_count, dv);
        chk({tag, ".div_reset_n"}, div_reset_n, rn);
        chk({tag, ".busy"}, busy, bz);
        chk({tag, ".seq_done"}, seq_done, dn);
    endtask

    task automatic wr(input int a, input bit r, input int n, input int d);
        wr_en = 1'b1;
        wr_addr = 4'(a);
        wr_note = {r, 3'(n)};
        wr_dur = 8'(d);
        m_rest[a] = r;
        m_note[a] = n;
        m_dur[a] = d;
        @(negedge inclk);
        wr_en = 1'b0;
    endtask

    task automatic rand_table(input int end_at);
        for (int i = 0; i < 16; i++)
            wr(i, $urandom_range(0, 3) == 0, $urandom_range(0, 7), (i == end_at) ? 0 : $urandom_range(1, 3));
    endtask

    function automatic void push(input int d, input bit rn, input bit bz, input int idx, input bit dn);
        exp_t e;
        e.div = d;
        e.rn = rn;
        e.busy = bz;
        e.idx = idx;
        e.done = dn;
        exp_q.push_back(e);
    endfunction

    // expected per-cycle outputs: each step is LOAD, RETRIG, then dur*T PLAY cycles
    task automatic build(input bit lp, input int maxc);
        int i;
        int d;
        exp_q.delete();
        d = m_div;
        i = 0;
        while (exp_q.size() < maxc) begin
            push(d, 0, 1, i, 0);
            if (m_dur[i] == 0) begin
                push(d, 0, 0, 0, 1);
                push(d, 0, 0, 0, 0);
                break;
            end
            if (!m_rest[i]) d = nd[m_note[i]];
            push(d, 0, 1, i, 0);
            repeat (m_dur[i] * T) push(d, !m_rest[i], 1, i, 0);
            if (i == 15 && !lp) begin
                push(d, 0, 0, 0, 1);
                push(d, 0, 0, 0, 0);
                break;
            end
            i = (i + 1) % 16;
        end
        while (exp_q.size() > maxc) void'(exp_q.pop_back());
    endtask

    // caller raises seq_start at a negedge; cycle 0 is the edge that samples it
    task automatic play();
        done_at = -1;
        busy_fall = -1;
        for (int n = 0; n < exp_q.size(); n++) begin
            @(negedge inclk);
            seq_start = 1'b0;
            seq_stop = 1'b0;
            chk($sformatf("div_count@%0d", n), div_count, exp_q[n].div);
            chk($sformatf("div_reset_n@%0d", n), div_reset_n, exp_q[n].rn);
            chk($sformatf("busy@%0d", n), busy, exp_q[n].busy);
            chk($sformatf("step_idx@%0d", n), step_idx, exp_q[n].idx);
            chk($sformatf("seq_done@%0d", n), seq_done, exp_q[n].done);
            if (seq_done === 1'b1 && done_at < 0) done_at = n;
            if (busy === 1'b0 && busy_fall < 0) busy_fall = n;
            m_div = exp_q[n].div;
        end
    endtask

    initial begin
        repeat (2) @(negedge inclk);
        chk_out("reset", 47801, 0, 0, 0);
        chk("reset.step_idx", step_idx, 0);
        Reset = 1'b1;

        man_en = 1'b1;
        man_note = 3'd5;
        @(negedge inclk);
        chk_out("man5", 28409, 1, 0, 0);
        man_note = 3'd2;
        @(negedge inclk);
        chk_out("man2_retrig", 37936, 0, 0, 0);
        @(negedge inclk);
        chk_out("man2_play", 37936, 1, 0, 0);
        man_en = 1'b0;
        @(negedge inclk);
        chk_out("man_off", 37936, 0, 0, 0);
        m_div = 37936;

        wr(0, 0, 0, 2);
        wr(1, 1, 0, 1);
        wr(2, 0, 7, 0);
        seq_start = 1'b1;
        build(0, 100000);
        play();
        chk("directed.done_at", done_at, 17);
        chk("directed.busy_fall", busy_fall, 17);

        for (int i = 0; i < 16; i++) wr(i, 0, i % 8, 1);
        loop_en = 1'b1;
        seq_start = 1'b1;
        build(1, 100);
        play();
        seq_stop = 1'b1;
        @(negedge inclk);
        seq_stop = 1'b0;
        chk_out("stop", m_div, 0, 0, 0);
        @(negedge inclk);
        chk_out("stop_after", m_div, 0, 0, 0);

        man_note = 3'd3;
        man_en = 1'b1;
        seq_start = 1'b1;
        build(1, 20);
        play();
        seq_start = 1'b1;
        seq_stop = 1'b1;
        @(negedge inclk);
        seq_start = 1'b0;
        seq_stop = 1'b0;
        chk_out("start_stop", m_div, 0, 0, 0);
        @(negedge inclk);
        chk_out("to_manual", nd[3], 1, 0, 0);
        man_en = 1'b0;
        @(negedge inclk);
        chk_out("manual_exit", nd[3], 0, 0, 0);
        m_div = nd[3];
        loop_en = 1'b0;

        rand_table($urandom_range(4, 15));
        seq_start = 1'b1;
        build(0, 100000);
        play();
        chk("randA.done_seen", done_at >= 0, 1);

        rand_table(16);
        seq_start = 1'b1;
        build(0, 100000);
        play();
        chk("randB.done_seen", done_at >= 0, 1);

        k = 2;
        for (int i = 0; i < 3; i++) k += m_dur[i] * T + 2;
        seq_start = 1'b1;
        build(0, k + 1);
        play();
        chk("mid_play.step_idx", step_idx, 3);
        Reset = 1'b0;
        @(negedge inclk);
        Reset = 1'b1;
        chk_out("mid_reset", 47801, 0, 0, 0);
        chk("mid_reset.step_idx", step_idx, 0);
        @(negedge inclk);
        chk_out("post_reset_idle", 47801, 0, 0, 0);
        m_div = nd[0];
        seq_start = 1'b1;
        build(0, 100000);
        play();
        chk("replay.done_seen", done_at >= 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
